// File: rtl/mips_pkg.sv
// Shared types for the load path: load-op encoding, error codes, FSM states,
// plus helpers for alignment checking and byte-lane generation.
package mips_pkg;

  typedef enum logic [2:0] {
    OpLb  = 3'd0,
    OpLbu = 3'd1,
    OpLh  = 3'd2,
    OpLhu = 3'd3,
    OpLw  = 3'd4,
    OpLwl = 3'd5,
    OpLwr = 3'd6
  } load_op_e;

  localparam logic [1:0] ErrNone       = 2'd0;
  localparam logic [1:0] ErrMisaligned = 2'd1;
  localparam logic [1:0] ErrTimeout    = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } load_state_e;

  // LWL/LWR are unaligned by design; only halfword and word loads can fault.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] offset);
    unique case (op)
      OpLh, OpLhu: is_misaligned = offset[0];
      OpLw:        is_misaligned = (offset != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [2:0] op, input logic [1:0] offset);
    unique case (op)
      OpLb, OpLbu: lane_enable = 4'b0001 << offset;
      OpLh, OpLhu: lane_enable = 4'b0011 << offset;
      default:     lane_enable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the addressed byte/half from a
// little-endian bus word, sign/zero extends it, or merges for LWL/LWR.
//   op     : load type (mips_pkg::load_op_e encoding)
//   offset : byte offset within the word (addr[1:0])
//   word   : raw bus read data
//   rt_old : current destination register value for LWL/LWR merge
//   data   : formatted writeback value
module load_align
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] rt_old,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[8*offset +: 8];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (op)
      OpLb:  data = {{24{byte_sel[7]}}, byte_sel};
      OpLbu: data = {24'h0, byte_sel};
      OpLh:  data = {{16{half_sel[15]}}, half_sel};
      OpLhu: data = {16'h0, half_sel};
      OpLw:  data = word;
      // LWL fills from the MSB end with the low bytes of the word.
      OpLwl: begin
        case (offset)
          2'd0:    data = {word[7:0],  rt_old[23:0]};
          2'd1:    data = {word[15:0], rt_old[15:0]};
          2'd2:    data = {word[23:0], rt_old[7:0]};
          default: data = word;
        endcase
      end
      // LWR fills from the LSB end with the high bytes of the word.
      OpLwr: begin
        case (offset)
          2'd0:    data = word;
          2'd1:    data = {rt_old[31:24], word[31:8]};
          2'd2:    data = {rt_old[31:16], word[31:16]};
          default: data = {rt_old[31:8],  word[31:24]};
        endcase
      end
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts one load at a time, issues a single word read on the
// Avalon-style bus, and returns a one-cycle writeback or error pulse.
//   clk, reset (sync, active-high)
//   req_*  : request handshake (valid/ready) with op, address, rt_old, dest
//   mem_*  : word-aligned bus read with byteenable and waitrequest stall
//   wb_*   : one-cycle writeback pulse; data/dest hold between pulses
//   err_*  : one-cycle error pulse (1 misaligned, 2 bus timeout)
module load_unit
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_rt_old,
  input  logic [4:0]  req_dest,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_regwrite,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  // Counter only needs to reach MAX_WAIT-1; the last stalled edge times out.
  localparam int unsigned CntW = (MAX_WAIT <= 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  load_state_e state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     rt_old_q, rt_old_d;
  logic [4:0]      dest_q, dest_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     mem_address_q, mem_address_d;
  logic            mem_read_q, mem_read_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_dest_q, wb_dest_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [1:0]      wb_regwrite_q, wb_regwrite_d;
  logic            err_valid_q, err_valid_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [31:0]     align_data;

  load_align u_align (
    .op     (op_q),
    .offset (off_q),
    .word   (mem_readdata),
    .rt_old (rt_old_q),
    .data   (align_data)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    off_d         = off_q;
    rt_old_d      = rt_old_q;
    dest_d        = dest_q;
    cnt_d         = cnt_q;
    mem_address_d = mem_address_q;
    mem_read_d    = 1'b0;
    mem_be_d      = 4'b0000;
    wb_valid_d    = 1'b0;
    wb_dest_d     = wb_dest_q;
    wb_data_d     = wb_data_q;
    wb_regwrite_d = 2'b00;
    err_valid_d   = 1'b0;
    err_code_d    = ErrNone;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d     = req_op;
          off_d    = req_addr[1:0];
          rt_old_d = req_rt_old;
          dest_d   = req_dest;
          cnt_d    = '0;
          if (is_misaligned(req_op, req_addr[1:0])) begin
            state_d     = StResp;
            err_valid_d = 1'b1;
            err_code_d  = ErrMisaligned;
          end else begin
            state_d       = StBusy;
            mem_address_d = {req_addr[31:2], 2'b00};
            mem_read_d    = 1'b1;
            mem_be_d      = lane_enable(req_op, req_addr[1:0]);
          end
        end
      end
      StBusy: begin
        if (!mem_waitrequest) begin
          state_d       = StResp;
          cnt_d         = '0;
          wb_valid_d    = 1'b1;
          wb_dest_d     = dest_q;
          wb_data_d     = align_data;
          wb_regwrite_d = (dest_q != 5'd0) ? 2'b11 : 2'b00;
        end else if (cnt_q == CntLast) begin
          state_d     = StResp;
          cnt_d       = '0;
          err_valid_d = 1'b1;
          err_code_d  = ErrTimeout;
        end else begin
          cnt_d      = cnt_q + CntW'(1);
          mem_read_d = 1'b1;
          mem_be_d   = mem_be_q;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= 3'd0;
      off_q         <= 2'd0;
      rt_old_q      <= 32'd0;
      dest_q        <= 5'd0;
      cnt_q         <= '0;
      mem_address_q <= 32'd0;
      mem_read_q    <= 1'b0;
      mem_be_q      <= 4'b0000;
      wb_valid_q    <= 1'b0;
      wb_dest_q     <= 5'd0;
      wb_data_q     <= 32'd0;
      wb_regwrite_q <= 2'b00;
      err_valid_q   <= 1'b0;
      err_code_q    <= ErrNone;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      off_q         <= off_d;
      rt_old_q      <= rt_old_d;
      dest_q        <= dest_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_be_q      <= mem_be_d;
      wb_valid_q    <= wb_valid_d;
      wb_dest_q     <= wb_dest_d;
      wb_data_q     <= wb_data_d;
      wb_regwrite_q <= wb_regwrite_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_byteenable = mem_be_q;
  assign wb_valid       = wb_valid_q;
  assign wb_dest        = wb_dest_q;
  assign wb_data        = wb_data_q;
  assign wb_regwrite    = wb_regwrite_q;
  assign err_valid      = err_valid_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
  import mips_pkg::*;

  localparam int unsigned MaxWait = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_rt_old;
  logic [4:0]  req_dest;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [1:0]  wb_regwrite;
  logic        err_valid;
  logic [1:0]  err_code;

  load_unit #(.MAX_WAIT(MaxWait)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_rt_old      (req_rt_old),
    .req_dest        (req_dest),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_byteenable  (mem_byteenable),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .wb_valid        (wb_valid),
    .wb_dest         (wb_dest),
    .wb_data         (wb_data),
    .wb_regwrite     (wb_regwrite),
    .err_valid       (err_valid),
    .err_code        (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] data;
    logic [4:0]  dest;
    logic [1:0]  rw;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  string cur    = "";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", cur, tag, obs, exp);
    end
  endtask

  // Reference formatter, written from the arithmetic definition of each op.
  function automatic logic [31:0] ref_data(input load_op_e op, input logic [1:0] k,
                                           input logic [31:0] rt, input logic [31:0] w);
    logic [31:0] b, h, mask;
    int          sh;
    b = (w >> (8 * k)) & 32'hFF;
    h = (w >> (8 * k)) & 32'hFFFF;
    case (op)
      OpLb:  ref_data = b[7]  ? (b | 32'hFFFF_FF00) : b;
      OpLbu: ref_data = b;
      OpLh:  ref_data = h[15] ? (h | 32'hFFFF_0000) : h;
      OpLhu: ref_data = h;
      OpLwl: begin
        sh       = 8 * (3 - int'(k));
        mask     = (sh == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - sh));
        ref_data = (w << sh) | (rt & mask);
      end
      OpLwr: begin
        sh       = 8 * int'(k);
        mask     = ~(32'hFFFF_FFFF >> sh);
        ref_data = (w >> sh) | (rt & mask);
      end
      default: ref_data = w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input load_op_e op, input logic [1:0] k);
    case (op)
      OpLb, OpLbu: ref_be = (k == 0) ? 4'h1 : (k == 1) ? 4'h2 : (k == 2) ? 4'h4 : 4'h8;
      OpLh, OpLhu: ref_be = k[1] ? 4'hC : 4'h3;
      default:     ref_be = 4'hF;
    endcase
  endfunction

  // One load end to end. stalls = waitrequest-high cycles; exp_lat = cycle
  // (relative to accept edge N) of the response pulse; exp_bus = mem_read cycles.
  task automatic do_load(input string name, input load_op_e op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [31:0] rdata,
                         input logic [4:0] dest, input int stalls, input int exp_lat,
                         input int exp_bus, input logic is_err, input logic [1:0] code);
    exp_t        e, got_e;
    int          bus;
    bit          got;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    cur      = name;
    e.is_err = is_err;
    e.code   = code;
    e.data   = ref_data(op, addr[1:0], rt, rdata);
    e.dest   = dest;
    e.rw     = (is_err || dest == 5'd0) ? 2'b00 : 2'b11;
    sb.push_back(e);
    exp_addr = {addr[31:2], 2'b00};
    exp_be   = ref_be(op, addr[1:0]);

    @(negedge clk);
    req_valid       = 1'b1;
    req_op          = op;
    req_addr        = addr;
    req_rt_old      = rt;
    req_dest        = dest;
    mem_readdata    = rdata;
    mem_waitrequest = 1'b0;
    check("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    bus = 0;
    got = 1'b0;
    got_e = e;
    for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
      @(negedge clk);
      if (wb_valid || err_valid) begin
        got = 1'b1;
        check("latency", cyc, exp_lat);
        check("mem_read_resp", {31'd0, mem_read}, 32'd0);
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          got_e = sb.pop_front();
          check("err_valid", {31'd0, err_valid}, {31'd0, got_e.is_err});
          check("err_code", {30'd0, err_code}, {30'd0, got_e.code});
          check("wb_valid", {31'd0, wb_valid}, {31'd0, !got_e.is_err});
          check("wb_regwrite", {30'd0, wb_regwrite}, {30'd0, got_e.rw});
          if (!got_e.is_err) begin
            check("wb_data", wb_data, got_e.data);
            check("wb_dest", {27'd0, wb_dest}, {27'd0, got_e.dest});
          end
        end
      end else if (mem_read) begin
        bus++;
        check("mem_address", mem_address, exp_addr);
        check("mem_byteenable", {28'd0, mem_byteenable}, {28'd0, exp_be});
        mem_waitrequest = (bus <= stalls);
      end
    end
    if (!got) begin
      check("resp_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    check("bus_cycles", bus, exp_bus);
    mem_waitrequest = 1'b0;

    @(negedge clk);
    check("wb_valid_after", {31'd0, wb_valid}, 32'd0);
    check("err_valid_after", {31'd0, err_valid}, 32'd0);
    check("err_code_after", {30'd0, err_code}, 32'd0);
    check("regwrite_after", {30'd0, wb_regwrite}, 32'd0);
    check("ready_after", {31'd0, req_ready}, 32'd1);
    if (got && !got_e.is_err) check("wb_data_hold", wb_data, got_e.data);
  endtask

  initial begin
    bit bad;
    reset           = 1'b1;
    req_valid       = 1'b0;
    req_op          = 3'd0;
    req_addr        = 32'd0;
    req_rt_old      = 32'd0;
    req_dest        = 5'd0;
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cur = "reset";
    check("req_ready", {31'd0, req_ready}, 32'd1);
    check("mem_read", {31'd0, mem_read}, 32'd0);
    check("mem_be", {28'd0, mem_byteenable}, 32'd0);
    check("mem_address", mem_address, 32'd0);
    check("wb_valid", {31'd0, wb_valid}, 32'd0);
    check("wb_data", wb_data, 32'd0);
    check("err_valid", {31'd0, err_valid}, 32'd0);

    do_load("lb_neg",   OpLb,  32'h0000_1003, 32'h0,         32'h80FF_FF7F, 5'd5,  0, 2, 1, 1'b0, ErrNone);
    do_load("lwl_k1",   OpLwl, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 5'd7,  0, 2, 1, 1'b0, ErrNone);
    do_load("lwr_k1",   OpLwr, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 5'd8,  0, 2, 1, 1'b0, ErrNone);
    do_load("lw_misal", OpLw,  32'h0000_0002, 32'h0,         32'h1234_5678, 5'd9,  0, 1, 0, 1'b1, ErrMisaligned);
    do_load("lhu_wait", OpLhu, 32'h0000_0006, 32'h0,         32'h8001_0000, 5'd10, 3, 5, 4, 1'b0, ErrNone);
    do_load("lh_dest0", OpLh,  32'h0000_0002, 32'h0,         32'h8001_7FFF, 5'd0,  0, 2, 1, 1'b0, ErrNone);
    do_load("lbu_k1",   OpLbu, 32'h0000_0001, 32'h0,         32'h0000_A500, 5'd11, 0, 2, 1, 1'b0, ErrNone);
    do_load("lw_wait1", OpLw,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 5'd12, 1, 3, 2, 1'b0, ErrNone);
    do_load("lh_misal", OpLh,  32'h0000_0101, 32'h0,         32'h0,         5'd13, 0, 1, 0, 1'b1, ErrMisaligned);
    do_load("lwl_k3",   OpLwl, 32'h0000_3003, 32'hFFFF_FFFF, 32'h0102_0304, 5'd14, 0, 2, 1, 1'b0, ErrNone);
    do_load("lwr_k0",   OpLwr, 32'h0000_3000, 32'hFFFF_FFFF, 32'h0102_0304, 5'd15, 0, 2, 1, 1'b0, ErrNone);
    do_load("lwl_k0",   OpLwl, 32'h0000_3000, 32'h1122_3344, 32'hAABB_CCDD, 5'd16, 2, 4, 3, 1'b0, ErrNone);
    do_load("lwr_k3",   OpLwr, 32'h0000_3003, 32'h1122_3344, 32'hAABB_CCDD, 5'd17, 0, 2, 1, 1'b0, ErrNone);
    do_load("timeout",  OpLw,  32'h0000_0020, 32'h0,         32'h5555_5555, 5'd18, 100, MaxWait + 1,
            MaxWait, 1'b1, ErrTimeout);

    // Reset mid-stall: the in-flight load must vanish without any pulse.
    cur = "reset_busy";
    @(negedge clk);
    req_valid       = 1'b1;
    req_op          = OpLw;
    req_addr        = 32'h0000_0040;
    req_dest        = 5'd20;
    mem_waitrequest = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mem_read_stall", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_op    = OpLh;
    req_addr  = 32'h0000_0101;
    @(negedge clk);
    check("mem_read", {31'd0, mem_read}, 32'd0);
    check("mem_be", {28'd0, mem_byteenable}, 32'd0);
    check("mem_address", mem_address, 32'd0);
    check("wb_data", wb_data, 32'd0);
    check("wb_dest", {27'd0, wb_dest}, 32'd0);
    reset           = 1'b0;
    req_valid       = 1'b0;
    mem_waitrequest = 1'b0;
    @(negedge clk);
    check("ready_release", {31'd0, req_ready}, 32'd1);
    bad = 1'b0;
    repeat (8) begin
      if (wb_valid || err_valid || mem_read) bad = 1'b1;
      @(negedge clk);
    end
    check("no_pulse", {31'd0, bad}, 32'd0);

    do_load("post_rst", OpLb, 32'h0000_0042, 32'h0, 32'h0012_3400, 5'd21, 0, 2, 1, 1'b0, ErrNone);
    cur = "end";
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter: MAX_WAIT, 255, max mem_waitrequest cycles tolerated before bus timeout.
REQ-002 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  load request present.
REQ-005 req_ready  out  1  unit can accept request this cycle.
REQ-006 req_op  in  3  load type: LB, LBU, LH, LHU, LW, LWL, LWR.
REQ-007 req_addr  in  32  effective byte address.
REQ-008 req_rt_old  in  32  current rt value, used for LWL/LWR merge.
REQ-009 req_dest  in  5  destination register index.
REQ-010 mem_address  out  32  word-aligned bus address.
REQ-011 mem_read  out  1  bus read strobe.
REQ-012 mem_byteenable  out  4  active byte lanes.
REQ-013 mem_waitrequest  in  1  bus stall.
REQ-014 mem_readdata  in  32  bus read data.
REQ-015 wb_valid  out  1  one-cycle writeback pulse to register file.
REQ-016 wb_dest  out  5  writeback register index.
REQ-017 wb_data  out  32  aligned/extended/merged load result.
REQ-018 wb_regwrite  out  2  register-file write code; 2'b11 = full write, 2'b00 = none.
REQ-019 err_valid  out  1  one-cycle error pulse.
REQ-020 err_code  out  2  0 none, 1 address misaligned, 2 bus timeout.

Function
REQ-021 FSM states IDLE, BUSY, RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 Accept on req_valid && req_ready; op, addr, rt_old, dest captured in that cycle's registers.
REQ-023 Misaligned request (LH/LHU addr[0]=1; LW addr[1:0]!=0) -> RESP directly, no bus cycle, err_code=1.
REQ-024 BUSY: mem_read=1, mem_address={addr[31:2],2'b00}, byteenable: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; LW 1111; LWL/LWR 1111.
REQ-025 Byte order little-endian: byte offset k occupies readdata[8k+7:8k].
REQ-026 BUSY holds all bus outputs stable while mem_waitrequest=1; on first edge with waitrequest=0, readdata captured, go RESP.
REQ-027 Wait counter increments each stalled BUSY cycle; reaching MAX_WAIT drops mem_read, goes RESP with err_code=2.
REQ-028 LB/LH sign-extend, LBU/LHU zero-extend selected byte/half; LW passes word.
REQ-029 LWL offset k: wb_data = {word[8k+7:0], rt_old[23-8k:0]}; k=3 gives full word.
REQ-030 LWR offset k: wb_data = {rt_old[31:32-8k], word[31:8k]}; k=0 gives full word.
REQ-031 RESP lasts exactly one cycle: on success wb_valid=1, wb_regwrite=2'b11 (2'b00 if dest=0), err_valid=0; on error wb_valid=0, wb_regwrite=2'b00, err_valid=1; then IDLE.
REQ-032 Latency: accept at edge N, mem_read high cycle N+1; zero wait -> wb_valid in cycle N+2; each stall cycle adds one.
REQ-033 Outside RESP: wb_valid=0, err_valid=0, wb_regwrite=2'b00, err_code=0; wb_data/wb_dest hold last value.
REQ-034 mem_read, mem_byteenable SHALL be 0 outside BUSY.

Reset
REQ-035 reset SHALL override all activity in any state, including mid-BUSY: state IDLE, mem_read=0, byteenable=0, mem_address=0, wb_*=0, err_*=0, wait counter=0.
REQ-036 Request presented during reset SHALL NOT be accepted; req_ready=1 from first cycle after reset release.

Structure
REQ-037 Load-op enum, err_code constants and FSM state enum SHALL live in shared package mips_pkg.
REQ-038 Alignment/extension/merge SHALL be one combinational sub-module load_align (op, offset, word, rt_old -> data).

Verification
REQ-039 LB addr 0x1003, readdata 0x80FF_FF7F, no wait -> wb_data 0xFFFF_FF80, wb_regwrite 11, wb_valid at N+2.
REQ-040 LWL addr 0x2001, readdata 0xAABB_CCDD, rt_old 0x1122_3344 -> wb_data 0xCCDD_3344; LWR same addr -> 0x11AA_BBCC.
REQ-041 LW addr 0x0002 -> no mem_read, err_valid=1 code 1 at N+1, wb_valid 0.
REQ-042 LHU addr 0x0006, waitrequest high 3 cycles, readdata 0x8001_0000 -> bus outputs stable 4 cycles, wb_data 0x0000_8001 at N+5.
REQ-043 waitrequest stuck high, MAX_WAIT=4 -> err_code 2 pulse, mem_read drops, req_ready returns next cycle.
REQ-044 reset asserted in BUSY mid-stall -> next cycle mem_read=0, IDLE, no wb_valid ever emitted for that request.
